// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   state_e         - access FSM encoding (IDLE = 0, WAIT = 1)
//   WORD_ALIGN_MASK - clears the byte-offset bits of a word address
//   BUBBLE_CTRL     - {RegWrite, MemToReg} value loaded into MEM/WB for a bubble
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [63:0] WORD_ALIGN_MASK = ~64'd3;

    localparam logic [1:0] BUBBLE_CTRL = 2'b00;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/acknowledge bus.
//   memReq   - request, held high for the whole access
//   memWe    - 1 = store
//   memAddr  - word-aligned address
//   memWdata - store data
//   memRdata - load data, valid in the hit cycle or the memAck cycle
//   memAck   - completion of a miss access
// Modports: master = MEM stage, slave = memory.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memAck
    );
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, resetN     - clock, asynchronous active-low reset (all outputs to 0)
//   bubble          - load a bubble (no register write, all fields cleared)
//   read_data, alu_result, write_reg, reg_write, mem_to_reg - captured values
//   readDataOut, ALUResultOut, writeRegOut, RegWriteOut, MemToRegOut - outputs
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              bubble,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        write_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [4:0]        writeRegOut,
    output logic              RegWriteOut,
    output logic              MemToRegOut
);

    logic [DATA_W-1:0] read_data_d, read_data_q;
    logic [DATA_W-1:0] alu_result_d, alu_result_q;
    logic [4:0]        write_reg_d, write_reg_q;
    logic              reg_write_d, reg_write_q;
    logic              mem_to_reg_d, mem_to_reg_q;

    always_comb begin
        read_data_d  = read_data;
        alu_result_d = alu_result;
        write_reg_d  = write_reg;
        reg_write_d  = reg_write;
        mem_to_reg_d = mem_to_reg;
        if (bubble) begin
            read_data_d                 = '0;
            alu_result_d                = '0;
            write_reg_d                 = '0;
            {reg_write_d, mem_to_reg_d} = BUBBLE_CTRL;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign readDataOut  = read_data_q;
    assign ALUResultOut = alu_result_q;
    assign writeRegOut  = write_reg_q;
    assign RegWriteOut  = reg_write_q;
    assign MemToRegOut  = mem_to_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EX/MEM register and WB.
// Issues loads/stores (single cycle on hit, req/ack handshake with stall on
// miss), resolves the branch and fills the MEM/WB register.
//   clk, resetN                 - clock, asynchronous active-low reset
//   hit, branchTarget, zeroFlag, ALUResult, readData2, writeReg,
//   MemRead, MemWrite, Branch, RegWrite, MemToReg - EX/MEM register outputs
//   mem                         - data-memory bus (master side)
//   stall                       - freeze PC, IF/ID, ID/EX, EX/MEM
//   pcSrc, branchTargetOut      - branch decision and target to the PC mux
//   readDataOut, ALUResultOut, writeRegOut, RegWriteOut, MemToRegOut - MEM/WB
//   memErr                      - sticky timeout error
// Optional feature: define MEM_TIMEOUT_EN to force completion of an access
// after TIMEOUT_CYCLES WAIT cycles without memAck (sets memErr).
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              hit,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              zeroFlag,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] readData2,
    input  logic [4:0]        writeReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              RegWrite,
    input  logic              MemToReg,
    mem_access_stage_if.master mem,
    output logic              stall,
    output logic              pcSrc,
    output logic [ADDR_W-1:0] branchTargetOut,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [4:0]        writeRegOut,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic              memErr
);

    state_e            state_q, state_d;
    logic              access, is_load;
    logic              mem_req, stall_int, bubble, tmo_expired;
    logic [DATA_W-1:0] cap_rdata;

    assign access  = MemRead | MemWrite;
    // Both MemRead and MemWrite set is treated as a store.
    assign is_load = MemRead & ~MemWrite;

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        stall_int = 1'b0;
        bubble    = 1'b0;
        cap_rdata = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_req = 1'b1;
                    if (hit) begin
                        cap_rdata = is_load ? mem.memRdata : '0;
                    end else begin
                        stall_int = 1'b1;
                        bubble    = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem.memAck) begin
                    cap_rdata = is_load ? mem.memRdata : '0;
                    state_d   = IDLE;
                end else if (tmo_expired) begin
                    // Forced completion: instruction retires with no load data.
                    state_d = IDLE;
                end else begin
                    stall_int = 1'b1;
                    bubble    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             mem_err_d, mem_err_q;

    // Counter holds the number of WAIT cycles already spent; the current
    // cycle is the last one allowed when it reaches TIMEOUT_CYCLES-1.
    assign tmo_expired = (state_q == WAIT) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        mem_err_d = mem_err_q;
        if (state_q == WAIT && state_d == WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_expired && !mem.memAck)         mem_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign memErr = mem_err_q;
`else
    assign tmo_expired = 1'b0;
    assign memErr      = 1'b0;
`endif

    // Request and stall are combinational from IDLE, so gate them with reset
    // to make them drop immediately when resetN falls.
    assign mem.memReq   = mem_req & resetN;
    assign stall        = stall_int & resetN;
    assign mem.memWe    = MemWrite & mem.memReq;
    assign mem.memAddr  = ADDR_W'(ALUResult) & WORD_ALIGN_MASK[ADDR_W-1:0];
    assign mem.memWdata = readData2;

    assign pcSrc           = Branch & zeroFlag;
    assign branchTargetOut = branchTarget;

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .resetN      (resetN),
        .bubble      (bubble),
        .read_data   (cap_rdata),
        .alu_result  (ALUResult),
        .write_reg   (writeReg),
        .reg_write   (RegWrite),
        .mem_to_reg  (MemToReg),
        .readDataOut (readDataOut),
        .ALUResultOut(ALUResultOut),
        .writeRegOut (writeRegOut),
        .RegWriteOut (RegWriteOut),
        .MemToRegOut (MemToRegOut)
    );

endmodule
